cache_block_mover: RTL and testbench

- Initiator that drives one read port and one write port of the 512x16 shared memory on behalf of a single cache controller.
- Serialises 2-word block operations:
  - dirty-block writeback (two word writes),
  - miss refill (two word reads).
- Returns the fill data to the cache with a one-cycle response pulse.
- One instance per cache; it is the requester end of the memory's address_read/readed and write/address_write/data_write ports.

---
 rtl/cache_block_mover_if.sv | 52 +++++
 rtl/cache_block_mover.sv | 197 +++++++++++++++++++
 tb/tb_cache_block_mover.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_block_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_block_mover_if
// Brief    : Bundle of the cache request/response channel and the shared
//            memory read/write ports serviced by cache_block_mover.
//            slave  - view taken by the block mover itself.
//            master - view taken by the environment (cache + memory).
// Revision : 1.0 - initial release
// ============================================================================
interface cache_block_mover_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  // Cache request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_wb;
  logic              req_fill;
  logic [ADDR_W-1:0] req_wb_addr;
  logic [DATA_W-1:0] req_wb_data0;
  logic [DATA_W-1:0] req_wb_data1;
  logic [ADDR_W-1:0] req_fill_addr;

  // Cache response channel
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data0;
  logic [DATA_W-1:0] resp_data1;

  // Shared memory ports
  logic [ADDR_W-1:0] mem_address_read;
  logic [DATA_W-1:0] mem_readed;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address_write;
  logic [DATA_W-1:0] mem_data_write;

  modport slave (
    input  req_valid, req_wb, req_fill, req_wb_addr, req_wb_data0,
           req_wb_data1, req_fill_addr, mem_readed,
    output req_ready, resp_valid, resp_data0, resp_data1,
           mem_address_read, mem_write, mem_address_write, mem_data_write
  );

  modport master (
    output req_valid, req_wb, req_fill, req_wb_addr, req_wb_data0,
           req_wb_data1, req_fill_addr, mem_readed,
    input  req_ready, resp_valid, resp_data0, resp_data1,
           mem_address_read, mem_write, mem_address_write, mem_data_write
  );

endinterface
`default_nettype wire

// File: rtl/cache_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : cache_block_mover
// Brief    : Cache-side initiator for the shared word memory. Serialises
//            2-word block operations: optional dirty writeback (two word
//            writes) followed by optional refill (two word reads), then a
//            one-cycle response pulse carrying the fill words.
// Options  : CACHE_BLOCK_MOVER_FWD_EN - when writeback and fill target the
//            same block, the fill words are taken from the latched
//            writeback data and the memory reads are skipped.
// Revision : 1.0 - initial release
// ============================================================================
module cache_block_mover #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_block_mover_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WB0  = 3'd1;
  localparam logic [2:0] WB1  = 3'd2;
  localparam logic [2:0] RD0  = 3'd3;
  localparam logic [2:0] RD1  = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  // Word-select mask: AND with ~ODD gives word0, OR with ODD gives word1.
  localparam logic [ADDR_W-1:0] ODD = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q,             state_d;
  logic              fill_q,              fill_d;
  logic [ADDR_W-1:0] wb_addr_q,           wb_addr_d;
  logic [ADDR_W-1:0] fill_addr_q,         fill_addr_d;
  logic [DATA_W-1:0] wb_data1_q,          wb_data1_d;
  logic              resp_valid_q,        resp_valid_d;
  logic [DATA_W-1:0] resp_data0_q,        resp_data0_d;
  logic [DATA_W-1:0] resp_data1_q,        resp_data1_d;
  logic              mem_write_q,         mem_write_d;
  logic [ADDR_W-1:0] mem_address_write_q, mem_address_write_d;
  logic [DATA_W-1:0] mem_data_write_q,    mem_data_write_d;
  logic [ADDR_W-1:0] mem_address_read_q,  mem_address_read_d;

`ifdef CACHE_BLOCK_MOVER_FWD_EN
  // Word0 of the writeback is only needed again when it is forwarded.
  logic [DATA_W-1:0] wb_data0_q, wb_data0_d;
  logic              fwd_hit;

  // Same block when the addresses differ at most in the word-select bit.
  assign fwd_hit = fill_q && (((wb_addr_q ^ fill_addr_q) & ~ODD) == '0);
`endif

  // Next-state and next-output decode; every memory-side output is computed
  // one cycle ahead so it is a flop output while the owning state is active.
  always_comb begin
    state_d             = state_q;
    fill_d              = fill_q;
    wb_addr_d           = wb_addr_q;
    fill_addr_d         = fill_addr_q;
    wb_data1_d          = wb_data1_q;
    resp_valid_d        = 1'b0;
    resp_data0_d        = resp_data0_q;
    resp_data1_d        = resp_data1_q;
    mem_write_d         = 1'b0;
    mem_address_write_d = mem_address_write_q;
    mem_data_write_d    = mem_data_write_q;
    mem_address_read_d  = mem_address_read_q;
`ifdef CACHE_BLOCK_MOVER_FWD_EN
    wb_data0_d          = wb_data0_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          fill_d      = bus.req_fill;
          wb_addr_d   = bus.req_wb_addr;
          fill_addr_d = bus.req_fill_addr;
          wb_data1_d  = bus.req_wb_data1;
`ifdef CACHE_BLOCK_MOVER_FWD_EN
          wb_data0_d  = bus.req_wb_data0;
`endif
          if (bus.req_wb) begin
            // WB0 is entered only from here, so word0 comes straight from
            // the request being accepted.
            state_d             = WB0;
            mem_write_d         = 1'b1;
            mem_address_write_d = bus.req_wb_addr & ~ODD;
            mem_data_write_d    = bus.req_wb_data0;
          end else if (bus.req_fill) begin
            state_d            = RD0;
            mem_address_read_d = bus.req_fill_addr & ~ODD;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end
        end
      end

      WB0: begin
        state_d             = WB1;
        mem_write_d         = 1'b1;
        mem_address_write_d = wb_addr_q | ODD;
        mem_data_write_d    = wb_data1_q;
      end

      WB1: begin
`ifdef CACHE_BLOCK_MOVER_FWD_EN
        if (fwd_hit) begin
          // The block in memory now equals the writeback data; return it
          // directly instead of reading it back.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data0_d = wb_data0_q;
          resp_data1_d = wb_data1_q;
        end else
`endif
        if (fill_q) begin
          state_d            = RD0;
          mem_address_read_d = fill_addr_q & ~ODD;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end
      end

      RD0: begin
        resp_data0_d       = bus.mem_readed;
        state_d            = RD1;
        mem_address_read_d = fill_addr_q | ODD;
      end

      RD1: begin
        resp_data1_d = bus.mem_readed;
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      fill_q              <= 1'b0;
      wb_addr_q           <= '0;
      fill_addr_q         <= '0;
      wb_data1_q          <= '0;
      resp_valid_q        <= 1'b0;
      resp_data0_q        <= '0;
      resp_data1_q        <= '0;
      mem_write_q         <= 1'b0;
      mem_address_write_q <= '0;
      mem_data_write_q    <= '0;
      mem_address_read_q  <= '0;
`ifdef CACHE_BLOCK_MOVER_FWD_EN
      wb_data0_q          <= '0;
`endif
    end else begin
      state_q             <= state_d;
      fill_q              <= fill_d;
      wb_addr_q           <= wb_addr_d;
      fill_addr_q         <= fill_addr_d;
      wb_data1_q          <= wb_data1_d;
      resp_valid_q        <= resp_valid_d;
      resp_data0_q        <= resp_data0_d;
      resp_data1_q        <= resp_data1_d;
      mem_write_q         <= mem_write_d;
      mem_address_write_q <= mem_address_write_d;
      mem_data_write_q    <= mem_data_write_d;
      mem_address_read_q  <= mem_address_read_d;
`ifdef CACHE_BLOCK_MOVER_FWD_EN
      wb_data0_q          <= wb_data0_d;
`endif
    end
  end

  // Ready is withheld during reset as well as whenever an operation is busy.
  assign bus.req_ready         = rst_n && (state_q == IDLE);
  assign bus.resp_valid        = resp_valid_q;
  assign bus.resp_data0        = resp_data0_q;
  assign bus.resp_data1        = resp_data1_q;
  assign bus.mem_write         = mem_write_q;
  assign bus.mem_address_write = mem_address_write_q;
  assign bus.mem_data_write    = mem_data_write_q;
  assign bus.mem_address_read  = mem_address_read_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_block_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_block_mover
// Brief    : Self-checking bench for cache_block_mover with a 512x16 memory
//            model and response/write scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_block_mover;

  localparam int AW = 9;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_block_mover_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: combinational read, posedge write.
  logic [DW-1:0] mem [0:511];
  logic          pre_we   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign bus.mem_readed = mem[bus.mem_address_read];

  int                 rsp_count = 0;
  logic [AW+DW-1:0]   obs_wr[$];
  logic [AW+DW-1:0]   exp_wr[$];
  logic [2*DW-1:0]    exp_rsp[$];
  int                 exp_lat[$];
  int                 n_tests = 0;
  int                 n_fail  = 0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_write) begin
      mem[bus.mem_address_write] <= bus.mem_data_write;
      obs_wr.push_back({bus.mem_address_write, bus.mem_data_write});
    end
    if (bus.resp_valid) rsp_count <= rsp_count + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request from IDLE and return the accept-to-response latency
  // (0 if no response within the budget). Returns in the response cycle.
  task automatic run_op(input logic wb, input logic fill,
                        input logic [AW-1:0] wa, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input logic [AW-1:0] fa,
                        output int lat);
    bus.req_wb = wb; bus.req_fill = fill; bus.req_wb_addr = wa;
    bus.req_wb_data0 = d0; bus.req_wb_data1 = d1; bus.req_fill_addr = fa;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_wb = 1'b0; bus.req_fill = 1'b0;
    bus.req_wb_addr = '0; bus.req_wb_data0 = '0; bus.req_wb_data1 = '0;
    bus.req_fill_addr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.resp_valid, bus.mem_write, bus.mem_address_read, bus.mem_address_write,
         bus.mem_data_write, bus.resp_data0, bus.resp_data1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b we=%b ra=%h wa=%h wd=%h d0=%h d1=%h, required all 0",
               bus.resp_valid, bus.mem_write, bus.mem_address_read, bus.mem_address_write,
               bus.mem_data_write, bus.resp_data0, bus.resp_data1);
    end
    n_tests++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: got %b required 0", bus.req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_idle: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_fill_only();
    int lat;
    logic [2*DW-1:0] e;
    int el;
    preload(9'd4, 16'h0001);
    preload(9'd5, 16'h0003);
    exp_rsp.push_back({16'h0001, 16'h0003}); exp_lat.push_back(3);
    run_op(1'b0, 1'b1, 9'd0, 16'h0, 16'h0, 9'd5, lat);
    e = exp_rsp.pop_front(); el = exp_lat.pop_front();
    n_tests++;
    if (lat !== el) begin
      n_fail++; $display("FAIL fill_latency: got %0d required %0d", lat, el);
    end
    n_tests++;
    if ({bus.resp_data0, bus.resp_data1} !== e) begin
      n_fail++; $display("FAIL fill_data: got %h/%h required %h", bus.resp_data0, bus.resp_data1, e);
    end
    n_tests++;
    if (bus.mem_address_read !== 9'd5) begin
      n_fail++; $display("FAIL fill_last_read_addr: got %0d required 5", bus.mem_address_read);
    end
    n_tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      n_fail++; $display("FAIL fill_no_writes: got %0d writes required %0d", obs_wr.size(), exp_wr.size());
    end
    obs_wr.delete(); exp_wr.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_wb_only();
    int lat;
    logic [2*DW-1:0] e;
    int el;
    logic [AW+DW-1:0] ew, ow;
    exp_wr.push_back({9'd256, 16'hAAAA});
    exp_wr.push_back({9'd257, 16'h5555});
    exp_rsp.push_back({16'h0001, 16'h0003}); exp_lat.push_back(3);
    run_op(1'b1, 1'b0, 9'd256, 16'hAAAA, 16'h5555, 9'd0, lat);
    e = exp_rsp.pop_front(); el = exp_lat.pop_front();
    n_tests++;
    if (lat !== el) begin
      n_fail++; $display("FAIL wb_latency: got %0d required %0d", lat, el);
    end
    n_tests++;
    if ({bus.resp_data0, bus.resp_data1} !== e) begin
      n_fail++; $display("FAIL wb_resp_held: got %h/%h required %h", bus.resp_data0, bus.resp_data1, e);
    end
    n_tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      n_fail++; $display("FAIL wb_write_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      ew = exp_wr.pop_front(); ow = obs_wr.pop_front();
      n_tests++;
      if (ow !== ew) begin
        n_fail++; $display("FAIL wb_write: got addr/data %h required %h", ow, ew);
      end
    end
    obs_wr.delete(); exp_wr.delete();
    n_tests++;
    if ({mem[256], mem[257]} !== {16'hAAAA, 16'h5555}) begin
      n_fail++; $display("FAIL wb_mem_contents: got %h/%h required aaaa/5555", mem[256], mem[257]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wb_fill(input string nm, input logic [AW-1:0] wa,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [AW-1:0] fa, input logic [2*DW-1:0] rsp,
                              input int elat);
    int lat;
    logic [2*DW-1:0] e;
    int el;
    logic [AW+DW-1:0] ew, ow;
    exp_wr.push_back({wa & 9'h1FE, d0});
    exp_wr.push_back({wa | 9'h001, d1});
    exp_rsp.push_back(rsp); exp_lat.push_back(elat);
    run_op(1'b1, 1'b1, wa, d0, d1, fa, lat);
    e = exp_rsp.pop_front(); el = exp_lat.pop_front();
    n_tests++;
    if (lat !== el) begin
      n_fail++; $display("FAIL %s_latency: got %0d required %0d", nm, lat, el);
    end
    n_tests++;
    if ({bus.resp_data0, bus.resp_data1} !== e) begin
      n_fail++; $display("FAIL %s_data: got %h/%h required %h", nm, bus.resp_data0, bus.resp_data1, e);
    end
    n_tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      n_fail++; $display("FAIL %s_write_count: got %0d required %0d", nm, obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      ew = exp_wr.pop_front(); ow = obs_wr.pop_front();
      n_tests++;
      if (ow !== ew) begin
        n_fail++; $display("FAIL %s_write: got addr/data %h required %h", nm, ow, ew);
      end
    end
    obs_wr.delete(); exp_wr.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_neither();
    int lat;
    logic [2*DW-1:0] e;
    int el;
    logic [AW-1:0] ra;
`ifdef CACHE_BLOCK_MOVER_FWD_EN
    ra = 9'd5;
`else
    ra = 9'd35;
`endif
    exp_rsp.push_back({16'hBEEF, 16'hCAFE}); exp_lat.push_back(1);
    run_op(1'b0, 1'b0, 9'd100, 16'h1357, 16'h2468, 9'd200, lat);
    e = exp_rsp.pop_front(); el = exp_lat.pop_front();
    n_tests++;
    if (lat !== el) begin
      n_fail++; $display("FAIL neither_latency: got %0d required %0d", lat, el);
    end
    n_tests++;
    if ({bus.resp_data0, bus.resp_data1} !== e) begin
      n_fail++; $display("FAIL neither_data_held: got %h/%h required %h", bus.resp_data0, bus.resp_data1, e);
    end
    n_tests++;
    if (bus.mem_address_read !== ra) begin
      n_fail++; $display("FAIL neither_read_addr_held: got %0d required %0d", bus.mem_address_read, ra);
    end
    n_tests++;
    if (obs_wr.size() != 0) begin
      n_fail++; $display("FAIL neither_no_writes: got %0d writes required 0", obs_wr.size());
    end
    obs_wr.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int rc0;
    logic [1:0] exp_rr;
    logic [2*DW-1:0] e;
    rc0 = rsp_count;
    exp_rsp.push_back({16'hAAAA, 16'h5555});
    exp_rsp.push_back({16'hAAAA, 16'h5555});
    bus.req_wb = 1'b0; bus.req_fill = 1'b1; bus.req_fill_addr = 9'd256;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      exp_rr = {(k == 4 || k == 8), (k == 3 || k == 7)};
      n_tests++;
      if ({bus.req_ready, bus.resp_valid} !== exp_rr) begin
        n_fail++; $display("FAIL b2b_ready_resp_cycle%0d: got ready/resp %b required %b",
                           k, {bus.req_ready, bus.resp_valid}, exp_rr);
      end
      if (bus.resp_valid && exp_rsp.size() > 0) begin
        e = exp_rsp.pop_front();
        n_tests++;
        if ({bus.resp_data0, bus.resp_data1} !== e) begin
          n_fail++; $display("FAIL b2b_data: got %h/%h required %h", bus.resp_data0, bus.resp_data1, e);
        end
      end
      if (k == 8) bus.req_valid = 1'b0;
      @(posedge clk); #1;
    end
    exp_rsp.delete();
    n_tests++;
    if (rsp_count - rc0 !== 2) begin
      n_fail++; $display("FAIL b2b_resp_count: got %0d required 2", rsp_count - rc0);
    end
  endtask

  task automatic test_reset_mid();
    int rc0;
    logic [AW+DW-1:0] ew, ow;
    exp_wr.push_back({9'd64, 16'h1111});
    exp_wr.push_back({9'd65, 16'h2222});
    bus.req_wb = 1'b1; bus.req_fill = 1'b1; bus.req_wb_addr = 9'd64;
    bus.req_wb_data0 = 16'h1111; bus.req_wb_data1 = 16'h2222; bus.req_fill_addr = 9'd4;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;           // WB0
    bus.req_valid = 1'b0;
    @(posedge clk); #1;           // WB1
    @(posedge clk); #1;           // RD0
    n_tests++;
    if (bus.mem_address_read !== 9'd4) begin
      n_fail++; $display("FAIL abort_in_rd0: got read addr %0d required 4", bus.mem_address_read);
    end
    rc0 = rsp_count;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_write, bus.mem_address_read, bus.mem_address_write,
         bus.mem_data_write, bus.resp_data0, bus.resp_data1} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got rdy=%b rv=%b we=%b ra=%h wa=%h wd=%h d0=%h d1=%h, required all 0",
               bus.req_ready, bus.resp_valid, bus.mem_write, bus.mem_address_read,
               bus.mem_address_write, bus.mem_data_write, bus.resp_data0, bus.resp_data1);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_ready_after: got %b required 1", bus.req_ready);
    end
    n_tests++;
    if (rsp_count !== rc0) begin
      n_fail++; $display("FAIL abort_no_resp: got %0d responses required 0", rsp_count - rc0);
    end
    n_tests++;
    if (obs_wr.size() != exp_wr.size()) begin
      n_fail++; $display("FAIL abort_write_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      ew = exp_wr.pop_front(); ow = obs_wr.pop_front();
      n_tests++;
      if (ow !== ew) begin
        n_fail++; $display("FAIL abort_write: got addr/data %h required %h", ow, ew);
      end
    end
    obs_wr.delete(); exp_wr.delete();
    n_tests++;
    if ({mem[64], mem[65]} !== {16'h1111, 16'h2222}) begin
      n_fail++; $display("FAIL abort_mem_kept: got %h/%h required 1111/2222", mem[64], mem[65]);
    end
  endtask

  initial begin
    int same_lat;
`ifdef CACHE_BLOCK_MOVER_FWD_EN
    same_lat = 3;
`else
    same_lat = 5;
`endif
    test_reset();
    test_fill_only();
    test_wb_only();
    test_wb_fill("wb_fill", 9'd34, 16'h1234, 16'h5678, 9'd4, {16'h0001, 16'h0003}, 5);
    // Writeback address has bit 0 set; it must still target block 34/35.
    test_wb_fill("same_block", 9'd35, 16'hBEEF, 16'hCAFE, 9'd34, {16'hBEEF, 16'hCAFE}, same_lat);
    test_neither();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
